// File: rtl/ddr3_mcb_pkg.sv
// Shared encodings for the DDR3 MCB initialisation sequencer: command codes,
// FSM states, mode-register indices and the per-rank command order.
package ddr3_mcb_pkg;

   localparam logic [1:0] CMD_NOP  = 2'd0;
   localparam logic [1:0] CMD_MRS  = 2'd1;
   localparam logic [1:0] CMD_ZQCL = 2'd2;

   localparam logic [2:0] MR0_IDX = 3'd0;
   localparam logic [2:0] MR1_IDX = 3'd1;
   localparam logic [2:0] MR2_IDX = 3'd2;
   localparam logic [2:0] MR3_IDX = 3'd3;

   // ZQCL long calibration is selected by A10 high.
   localparam logic [15:0] ZQCL_ADDR = 16'h0400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_HOLD,
      ST_CKE_WAIT,
      ST_XPR_WAIT,
      ST_CMD,
      ST_WAIT,
      ST_DONE
   } init_state_e;

   // Per-rank command order; the encoding order is the issue order.
   typedef enum logic [2:0] {
      SEQ_MR2,
      SEQ_MR3,
      SEQ_MR1,
      SEQ_MR0,
      SEQ_ZQCL
   } seq_step_e;

   function automatic logic [2:0] seq_ba(input seq_step_e step);
      case (step)
         SEQ_MR2: return MR2_IDX;
         SEQ_MR3: return MR3_IDX;
         SEQ_MR1: return MR1_IDX;
         SEQ_MR0: return MR0_IDX;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/ddr3_mcb_wait_cnt.sv
// Loadable down-counter shared by every timed state of the init sequencer.
// Holds at zero until the next load.
module ddr3_mcb_wait_cnt #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   // NOTE: sequential state is always written with <= so every flop samples
   // pre-edge values and simulation matches the synthesised netlist.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - 1'b1;
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/ddr3_mcb_init_seq.sv
// DDR3 power-up/initialisation sequencer: RESET#/CKE timing, then MR2, MR3,
// MR1, MR0, ZQCL per rank over a valid/ready port. Define
// DDR3_MCB_INIT_REINIT_EN to allow init_begin in DONE to rerun the sequence.
module ddr3_mcb_init_seq
   import ddr3_mcb_pkg::*;
#(
   parameter int          NUM_RANKS    = 1,
   parameter int          CNT_W        = 17,
   parameter int          T_RESET_CYC  = 14000,
   parameter int          T_CKE_CYC    = 35000,
   parameter int          T_XPR_CYC    = 10,
   parameter int          T_MRD_CYC    = 4,
   parameter int          T_MOD_CYC    = 12,
   parameter int          T_ZQINIT_CYC = 512,
   parameter logic [15:0] MR0_VAL      = 16'h0000,
   parameter logic [15:0] MR1_VAL      = 16'h0000,
   parameter logic [15:0] MR2_VAL      = 16'h0000,
   parameter logic [15:0] MR3_VAL      = 16'h0000
) (
   input  logic                 ddr3_mcb_clk,
   input  logic                 ddr3_mcb_rst_n,
   input  logic                 init_begin,
   output logic                 init_ready,
   output logic                 init_busy,
   output logic                 ddr_rst_n,
   output logic                 ddr_cke,
   output logic                 ddr_odt,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [1:0]           cmd_code,
   output logic [2:0]           cmd_ba,
   output logic [15:0]          cmd_addr,
   output logic [NUM_RANKS-1:0] cmd_cs
);

   localparam int RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
   localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NUM_RANKS - 1);

   // The counter runs T-1 down to 0, so each wait lasts exactly T cycles.
   localparam logic [CNT_W-1:0] RESET_LD  = CNT_W'(T_RESET_CYC - 1);
   localparam logic [CNT_W-1:0] CKE_LD    = CNT_W'(T_CKE_CYC - 1);
   localparam logic [CNT_W-1:0] XPR_LD    = CNT_W'(T_XPR_CYC - 1);
   localparam logic [CNT_W-1:0] MRD_LD    = CNT_W'(T_MRD_CYC - 1);
   localparam logic [CNT_W-1:0] MOD_LD    = CNT_W'(T_MOD_CYC - 1);
   localparam logic [CNT_W-1:0] ZQINIT_LD = CNT_W'(T_ZQINIT_CYC - 1);

   init_state_e       state, next_state;
   seq_step_e         seq, next_seq;
   logic [RANK_W-1:0] rank, next_rank;

   logic              cnt_load, cnt_zero;
   logic [CNT_W-1:0]  cnt_load_val, cnt_value;

   logic                 rst_d, cke_d, valid_d, ready_d, busy_d;
   logic [1:0]           code_d;
   logic [2:0]           ba_d;
   logic [15:0]          addr_d;
   logic [NUM_RANKS-1:0] cs_d;

   function automatic logic [CNT_W-1:0] post_wait_ld(input seq_step_e step);
      case (step)
         SEQ_MR0:  return MOD_LD;
         SEQ_ZQCL: return ZQINIT_LD;
         default:  return MRD_LD;
      endcase
   endfunction

   function automatic logic [15:0] step_addr(input seq_step_e step);
      case (step)
         SEQ_MR2: return MR2_VAL;
         SEQ_MR3: return MR3_VAL;
         SEQ_MR1: return MR1_VAL;
         SEQ_MR0: return MR0_VAL;
         default: return ZQCL_ADDR;
      endcase
   endfunction

   ddr3_mcb_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk      (ddr3_mcb_clk),
      .rst_n    (ddr3_mcb_rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .value    (cnt_value),
      .zero     (cnt_zero)
   );

   // State, sequence position and registered outputs.
   always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
      if (!ddr3_mcb_rst_n) begin
         state      <= ST_IDLE;
         seq        <= SEQ_MR2;
         rank       <= '0;
         ddr_rst_n  <= 1'b0;
         ddr_cke    <= 1'b0;
         ddr_odt    <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_code   <= CMD_NOP;
         cmd_ba     <= '0;
         cmd_addr   <= '0;
         cmd_cs     <= '0;
         init_ready <= 1'b0;
         init_busy  <= 1'b0;
      end else begin
         state      <= next_state;
         seq        <= next_seq;
         rank       <= next_rank;
         ddr_rst_n  <= rst_d;
         ddr_cke    <= cke_d;
         ddr_odt    <= 1'b0;
         cmd_valid  <= valid_d;
         cmd_code   <= code_d;
         cmd_ba     <= ba_d;
         cmd_addr   <= addr_d;
         cmd_cs     <= cs_d;
         init_ready <= ready_d;
         init_busy  <= busy_d;
      end
   end

   // Next state; the counter is loaded on the edge that enters a timed state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      next_state   = state;
      next_seq     = seq;
      next_rank    = rank;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state)
         ST_IDLE: begin
            if (init_begin) begin
               next_state   = ST_RST_HOLD;
               cnt_load     = 1'b1;
               cnt_load_val = RESET_LD;
            end
         end
         ST_RST_HOLD: begin
            if (cnt_zero) begin
               next_state   = ST_CKE_WAIT;
               cnt_load     = 1'b1;
               cnt_load_val = CKE_LD;
            end
         end
         ST_CKE_WAIT: begin
            if (cnt_zero) begin
               next_state   = ST_XPR_WAIT;
               cnt_load     = 1'b1;
               cnt_load_val = XPR_LD;
            end
         end
         ST_XPR_WAIT: begin
            if (cnt_zero) next_state = ST_CMD;
         end
         ST_CMD: begin
            if (cmd_valid && cmd_ready) begin
               next_state   = ST_WAIT;
               cnt_load     = 1'b1;
               cnt_load_val = post_wait_ld(seq);
            end
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               if (seq != SEQ_ZQCL) begin
                  next_seq   = seq_step_e'(seq + 3'd1);
                  next_state = ST_CMD;
               end else if (rank != LAST_RANK) begin
                  next_rank  = rank + 1'b1;
                  next_seq   = SEQ_MR2;
                  next_state = ST_CMD;
               end else begin
                  next_state = ST_DONE;
               end
            end
         end
         ST_DONE: begin
`ifdef DDR3_MCB_INIT_REINIT_EN
            if (init_begin) begin
               next_state   = ST_RST_HOLD;
               next_seq     = SEQ_MR2;
               next_rank    = '0;
               cnt_load     = 1'b1;
               cnt_load_val = RESET_LD;
            end
`endif
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Output values for the state being entered, registered on the same edge.
   always_comb begin
      rst_d   = 1'b1;
      cke_d   = 1'b1;
      valid_d = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      code_d  = CMD_NOP;
      ba_d    = '0;
      addr_d  = '0;
      cs_d    = '0;
      case (next_state)
         ST_IDLE: begin
            rst_d  = 1'b0;
            cke_d  = 1'b0;
            busy_d = 1'b0;
         end
         ST_RST_HOLD: begin
            rst_d = 1'b0;
            cke_d = 1'b0;
         end
         ST_CKE_WAIT: cke_d = 1'b0;
         ST_CMD: begin
            valid_d = 1'b1;
            code_d  = (next_seq == SEQ_ZQCL) ? CMD_ZQCL : CMD_MRS;
            ba_d    = seq_ba(next_seq);
            addr_d  = step_addr(next_seq);
            cs_d    = NUM_RANKS'(1) << next_rank;
         end
         ST_DONE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         default: ;
      endcase
   end

   // The counter is only ever left idle at zero outside the timed states.
   idle_cnt_zero: assert property (@(posedge ddr3_mcb_clk) disable iff (!ddr3_mcb_rst_n)
      (state == ST_IDLE || state == ST_DONE) |-> (cnt_value == '0));

endmodule

// File: tb/tb_ddr3_mcb_init_seq.sv
// Directed bench for ddr3_mcb_init_seq: timing, backpressure, two-rank loop,
// async reset and init_begin handling (with or without DDR3_MCB_INIT_REINIT_EN).
module tb_ddr3_mcb_init_seq;

   localparam int          NR       = 2;
   localparam int          T_RESET  = 8;
   localparam int          T_CKE    = 16;
   localparam int          T_XPR    = 3;
   localparam int          T_MRD    = 2;
   localparam int          T_MOD    = 4;
   localparam int          T_ZQINIT = 6;
   localparam logic [15:0] MR0_V    = 16'h0D70;
   localparam logic [15:0] MR1_V    = 16'h0044;
   localparam logic [15:0] MR2_V    = 16'h0018;
   localparam logic [15:0] MR3_V    = 16'h0004;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          init_begin = 1'b0;
   logic          cmd_ready = 1'b1;
   logic          init_ready, init_busy, ddr_rst_n, ddr_cke, ddr_odt, cmd_valid;
   logic [1:0]    cmd_code;
   logic [2:0]    cmd_ba;
   logic [15:0]   cmd_addr;
   logic [NR-1:0] cmd_cs;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_hs     = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (cmd_valid && cmd_ready) n_hs++;

   ddr3_mcb_init_seq #(
      .NUM_RANKS(NR), .CNT_W(17),
      .T_RESET_CYC(T_RESET), .T_CKE_CYC(T_CKE), .T_XPR_CYC(T_XPR),
      .T_MRD_CYC(T_MRD), .T_MOD_CYC(T_MOD), .T_ZQINIT_CYC(T_ZQINIT),
      .MR0_VAL(MR0_V), .MR1_VAL(MR1_V), .MR2_VAL(MR2_V), .MR3_VAL(MR3_V)
   ) dut (
      .ddr3_mcb_clk   (clk),
      .ddr3_mcb_rst_n (rst_n),
      .init_begin     (init_begin),
      .init_ready     (init_ready),
      .init_busy      (init_busy),
      .ddr_rst_n      (ddr_rst_n),
      .ddr_cke        (ddr_cke),
      .ddr_odt        (ddr_odt),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_code       (cmd_code),
      .cmd_ba         (cmd_ba),
      .cmd_addr       (cmd_addr),
      .cmd_cs         (cmd_cs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Expected per-rank command table, index 0..4 = MR2, MR3, MR1, MR0, ZQCL.
   function automatic int exp_ba(input int k);
      case (k)
         0: return 2;
         1: return 3;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [15:0] exp_addr(input int k);
      case (k)
         0: return MR2_V;
         1: return MR3_V;
         2: return MR1_V;
         3: return MR0_V;
         default: return 16'h0400;
      endcase
   endfunction

   function automatic int exp_wait(input int k);
      if (k < 3) return T_MRD;
      if (k == 3) return T_MOD;
      return T_ZQINIT;
   endfunction

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_init_ready"}, 32'(init_ready), 0);
      chk({pfx, "_init_busy"},  32'(init_busy), 0);
      chk({pfx, "_ddr_rst_n"},  32'(ddr_rst_n), 0);
      chk({pfx, "_ddr_cke"},    32'(ddr_cke), 0);
      chk({pfx, "_ddr_odt"},    32'(ddr_odt), 0);
      chk({pfx, "_cmd_valid"},  32'(cmd_valid), 0);
      chk({pfx, "_cmd_code"},   32'(cmd_code), 0);
      chk({pfx, "_cmd_ba"},     32'(cmd_ba), 0);
      chk({pfx, "_cmd_addr"},   32'(cmd_addr), 0);
      chk({pfx, "_cmd_cs"},     32'(cmd_cs), 0);
   endtask

   // Entered at the negedge just after the edge that left IDLE (or DONE).
   task automatic run_seq(input int hold, input bit bp);
      int t_prev, n_wait, hs0;
      t_prev = cyc;
      hs0    = n_hs;
      chk("start_busy", 32'(init_busy), 1);
      chk("start_ddr_rst_n", 32'(ddr_rst_n), 0);
      chk("start_init_ready", 32'(init_ready), 0);
      for (int i = 0; i < T_RESET - 1; i++) begin
         if (i == hold) init_begin = 1'b0;
         step();
      end
      init_begin = 1'b0;
      chk("rst_hold_last", 32'(ddr_rst_n), 0);
      step();
      chk("rst_rise", 32'(ddr_rst_n), 1);
      chk("cke_low_after_rst", 32'(ddr_cke), 0);
      for (int i = 0; i < T_CKE - 1; i++) begin
         init_begin = (i == 5);
         step();
      end
      init_begin = 1'b0;
      chk("cke_wait_last", 32'(ddr_cke), 0);
      step();
      chk("cke_rise", 32'(ddr_cke), 1);
      repeat (T_XPR - 1) step();
      chk("xpr_no_cmd", 32'(cmd_valid), 0);
      step();
      for (int r = 0; r < NR; r++) begin
         for (int k = 0; k < 5; k++) begin
            if (!(r == 0 && k == 0)) begin
               step();
               chk("valid_drop", 32'(cmd_valid), 0);
               n_wait = 0;
               while (!cmd_valid && n_wait < 100) begin
                  step();
                  n_wait++;
               end
               chk("cmd_gap", 32'(cyc - t_prev), 32'(exp_wait(k == 0 ? 4 : k - 1) + 1));
            end
            if (bp && r == 0 && k == 1) begin
               cmd_ready = 1'b0;
               for (int i = 0; i < 5; i++) begin
                  chk("bp_valid", 32'(cmd_valid), 1);
                  chk("bp_ba", 32'(cmd_ba), 3);
                  chk("bp_addr", 32'(cmd_addr), 32'(MR3_V));
                  step();
               end
               cmd_ready = 1'b1;
            end
            chk("cmd_valid", 32'(cmd_valid), 1);
            chk("cmd_code", 32'(cmd_code), (k == 4) ? 2 : 1);
            chk("cmd_ba", 32'(cmd_ba), 32'(exp_ba(k)));
            chk("cmd_addr", 32'(cmd_addr), 32'(exp_addr(k)));
            chk("cmd_cs", 32'(cmd_cs), (r == 0) ? 1 : 2);
            t_prev = cyc;
         end
      end
      repeat (T_ZQINIT) step();
      chk("zq_wait_not_ready", 32'(init_ready), 0);
      step();
      chk("done_ready", 32'(init_ready), 1);
      chk("done_busy", 32'(init_busy), 0);
      chk("done_ddr_rst_n", 32'(ddr_rst_n), 1);
      chk("done_cke", 32'(ddr_cke), 1);
      chk("done_odt", 32'(ddr_odt), 0);
      chk("done_valid", 32'(cmd_valid), 0);
      chk("cmd_count", 32'(n_hs - hs0), 32'(NR * 5));
   endtask

   initial begin
      int hs, n_wait;
      #1 rst_n = 1'b0;
      repeat (3) step();
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (3) step();
      chk("idle_busy", 32'(init_busy), 0);
      chk("idle_ddr_rst_n", 32'(ddr_rst_n), 0);

      init_begin = 1'b1;
      step();
      run_seq(0, 1'b1);

      hs = n_hs;
      init_begin = 1'b1;
      step();
`ifdef DDR3_MCB_INIT_REINIT_EN
      chk("reinit_ready", 32'(init_ready), 0);
      chk("reinit_ddr_rst_n", 32'(ddr_rst_n), 0);
      chk("reinit_cke", 32'(ddr_cke), 0);
      chk("reinit_busy", 32'(init_busy), 1);
      run_seq(0, 1'b0);
`else
      init_begin = 1'b0;
      repeat (20) step();
      chk("done_hold_ready", 32'(init_ready), 1);
      chk("done_hold_busy", 32'(init_busy), 0);
      chk("done_hold_cke", 32'(ddr_cke), 1);
      chk("done_no_cmd", 32'(n_hs - hs), 0);
`endif

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      init_begin = 1'b1;
      step();
      init_begin = 1'b0;
      n_wait = 0;
      while (!(cmd_valid && cmd_ba == 3'd1) && n_wait < 200) begin
         step();
         n_wait++;
      end
      chk("mr1_reached", 32'(cmd_valid), 1);
      chk("mr1_ba", 32'(cmd_ba), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async");
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("post_reset_busy", 32'(init_busy), 0);
      chk("post_reset_ddr_rst_n", 32'(ddr_rst_n), 0);

      init_begin = 1'b1;
      step();
      run_seq(3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr3_mcb_init_seq.md
Name: ddr3_mcb_init_seq

Overview:
- Parametrised DDR3 power-up/initialisation sequencer for the MCB.
- Drives DRAM RESET#, CKE and ODT, then issues MRS (MR2, MR3, MR1, MR0) and ZQCL per rank through a valid/ready command port into the MCB command mux.
- Successor to the fixed single-rank init block: adds configurable timing, multi-rank support, programmable MR contents, and command backpressure.
- Asserts init_ready when the sequence completes.

Parameters:
- NUM_RANKS, 1, number of chip selects initialised in turn (1..4).
- CNT_W, 17, wait-counter width; every T_* value must be ≤ 2^CNT_W-1.
- T_RESET_CYC, 14000, cycles RESET# is held low (≥200 us).
- T_CKE_CYC, 35000, cycles from RESET# high to CKE high (≥500 us).
- T_XPR_CYC, 10, cycles from CKE high to first command.
- T_MRD_CYC, 4, cycles after MR2/MR3/MR1 before next command.
- T_MOD_CYC, 12, cycles after MR0 before ZQCL.
- T_ZQINIT_CYC, 512, cycles after ZQCL before next rank or done.
- MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL, 16'h0000 each, address-bus contents for each MRS.

Ports:
- ddr3_mcb_clk  in  1  controller clock.
- ddr3_mcb_rst_n  in  1  asynchronous active-low reset.
- init_begin  in  1  start request, sampled in IDLE.
- init_ready  out  1  sequence complete, sticky.
- init_busy  out  1  high in every state except IDLE and DONE.
- ddr_rst_n  out  1  DRAM RESET#, active low.
- ddr_cke  out  1  DRAM CKE.
- ddr_odt  out  1  DRAM ODT, held low for the whole of init.
- cmd_valid  out  1  command request.
- cmd_ready  in  1  command accepted by mux.
- cmd_code  out  2  0=NOP, 1=MRS, 2=ZQCL.
- cmd_ba  out  3  MRS bank address = MR index; 0 for ZQCL.
- cmd_addr  out  16  MRx_VAL for MRS; bit 10 = 1 for ZQCL, others 0.
- cmd_cs  out  NUM_RANKS  one-hot rank select.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous, active-low, on ddr3_mcb_rst_n, clocked by ddr3_mcb_clk.
- Reset values: ddr_rst_n=0, ddr_cke=0, ddr_odt=0, cmd_valid=0, cmd_code=0, cmd_ba=0, cmd_addr=0, cmd_cs=0, init_ready=0, init_busy=0; state IDLE, rank index 0. All outputs are registered.
- States and transitions:
  - IDLE: go to RST_HOLD on init_begin=1.
  - RST_HOLD: ddr_rst_n=0 for exactly T_RESET_CYC cycles, then CKE_WAIT.
  - CKE_WAIT: ddr_rst_n=1, ddr_cke=0 for T_CKE_CYC cycles, then XPR_WAIT.
  - XPR_WAIT: ddr_cke=1 for T_XPR_CYC cycles, then CMD.
  - CMD: present the current command; on completion go to WAIT.
  - WAIT: count the command's post-wait, then advance.
  - DONE: terminal.
- Command order per rank: MR2, MR3, MR1, MR0, ZQCL. Post-waits: T_MRD_CYC after MR2/MR3/MR1, T_MOD_CYC after MR0, T_ZQINIT_CYC after ZQCL.
- Rank loop: after the ZQCL wait, if rank < NUM_RANKS-1, increment rank and restart at MR2 with no XPR wait; otherwise go to DONE.
- Handshake: cmd_valid rises on entry to CMD. cmd_valid and the payload stay stable until the cycle cmd_valid&cmd_ready=1. cmd_valid drops the following cycle. The wait counter loads in the handshake cycle, so WAIT lasts exactly its T_* value.
- Wait counter: loads T-1 and decrements to 0; the transition occurs on the 0 cycle. T_*=1 gives a 1-cycle wait.
- DONE: init_ready=1 and init_busy=0. ddr_rst_n=1 and ddr_cke=1 stay high. ddr_odt stays 0 (ODT ownership passes to the scheduler). init_begin is ignored.
- init_begin while busy: ignored. Holding init_begin high in IDLE starts exactly one sequence.
- cmd_ready while cmd_valid=0: ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously), and the sequence restarts only on a new init_begin.

Optional Feature:
- DDR3_MCB_INIT_REINIT_EN
- Defined: init_begin=1 in DONE clears init_ready next cycle, drives ddr_cke=0 and ddr_rst_n=0, resets rank to 0 and re-enters RST_HOLD.
- Undefined: DONE is terminal until reset.

Decomposition:
- Package ddr3_mcb_pkg holds:
  - cmd_code constants (CMD_NOP, CMD_MRS, CMD_ZQCL);
  - init state encoding;
  - MR index constants.
- Sub-module ddr3_mcb_wait_cnt: loadable CNT_W down-counter with load, value and zero flag. Instantiated once and shared by all wait states.

Test Plan:
- Timing (T_RESET=8, T_CKE=16, T_XPR=3, T_MRD=2, T_MOD=4, T_ZQINIT=6, cmd_ready=1): pulse init_begin -> ddr_rst_n rises 8 cycles after leaving IDLE, ddr_cke 16 later. MRS ba order 2,3,1,0 with cmd_addr=MRx_VAL, then ZQCL addr=16'h0400. Handshake gaps are 2,2,2,4 cycles. init_ready rises 6 cycles after the ZQCL handshake.
- Backpressure: hold cmd_ready=0 for 5 cycles on MR3 -> cmd_valid stays high and the payload is constant. The T_MRD count starts only at the handshake.
- NUM_RANKS=2 -> cmd_cs=01 for the full MR2..ZQCL set, then 10. Exactly 10 commands, with no second XPR wait.
- Async reset mid-MR1 -> all outputs reach reset values within the same cycle. A new init_begin replays the full sequence from RST_HOLD.
- init_begin pulsed during CKE_WAIT and in DONE (macro undefined) -> no effect; command count unchanged.
- With DDR3_MCB_INIT_REINIT_EN: init_begin in DONE -> init_ready=0 next cycle, ddr_rst_n=0, and the full sequence repeats.
